// File: rtl/neopixel_stream.sv
// WS2812 bit serialiser: turns buffer bytes into 8-tick waveforms on neoData and
// raises the pattern/bit/pixel overflow strobes the parent uses to sequence pixels.
module neopixel_stream #(
  parameter int BUFFER_END = 59,
  localparam int BUFFER_BITS = $clog2(BUFFER_END + 1)
) (
  input  logic                   clk7mhz,
  input  logic                   rstn,
  input  logic                   reg_ctrl_init,
  input  logic                   reg_ctrl_run,
  input  logic                   reg_ctrl_limit,
  input  logic                   reg_ctrl_32bit,
  input  logic                   state,
  input  logic [12:0]            reg_max,
  input  logic [BUFFER_BITS-1:0] pixel_index,
  input  logic [7:0]             pixel_data,
  output logic [BUFFER_BITS-1:0] pixel_addr,
  output logic                   neoData,
  output logic [2:0]             bit_pattern_index,
  output logic [4:0]             pixel_bit_index,
  output logic [BUFFER_BITS-1:0] pixel_index_max,
  output logic                   stream_output,
  output logic                   stream_reset,
  output logic                   stream_pattern_of,
  output logic                   stream_bit_of,
  output logic                   stream_pixel_of
);

  // Two spare bits so pixel_index+3 can never wrap, even for tiny buffers.
  localparam int XW = BUFFER_BITS + 2;

  logic [4:0]    last_bit;
  logic [XW-1:0] idx_ext;
  logic [XW-1:0] max_ext;
  logic [XW-1:0] idx_last;
  logic          last_pixel;
  logic          tx_bit;
  logic          tick_high;
  logic          unused_reg_max;

  assign stream_output = !state && reg_ctrl_run;
  assign stream_reset  = state;

  assign pixel_index_max = reg_ctrl_limit ? BUFFER_BITS'(reg_max) : BUFFER_BITS'(BUFFER_END);
  assign unused_reg_max  = ^reg_max;

  assign last_bit = reg_ctrl_32bit ? 5'd23 : 5'd7;

  assign stream_pattern_of = stream_output && (bit_pattern_index == 3'd7);
  assign stream_bit_of     = stream_pattern_of && (pixel_bit_index == last_bit);

  // In 32-bit mode the last pixel is the one whose 3 sent bytes reach the end index.
  assign idx_ext    = XW'(pixel_index);
  assign max_ext    = XW'(pixel_index_max);
  assign idx_last   = reg_ctrl_32bit ? idx_ext + XW'(3) : idx_ext;
  assign last_pixel = idx_last >= max_ext;

  assign stream_pixel_of = stream_bit_of && last_pixel;

  assign pixel_addr = reg_ctrl_32bit ? pixel_index + BUFFER_BITS'(pixel_bit_index[4:3])
                                     : pixel_index;

  // MSB first: bit 7 - n, which is the 3-bit complement of n.
  assign tx_bit    = pixel_data[~pixel_bit_index[2:0]];
  assign tick_high = tx_bit ? (bit_pattern_index < 3'd5) : (bit_pattern_index < 3'd2);

  always_ff @(posedge clk7mhz or negedge rstn) begin
    if (!rstn) begin
      bit_pattern_index <= 3'd0;
      pixel_bit_index   <= 5'd0;
      neoData           <= 1'b0;
    end else if (reg_ctrl_init || !stream_output) begin
      bit_pattern_index <= 3'd0;
      pixel_bit_index   <= 5'd0;
      neoData           <= 1'b0;
    end else begin
      bit_pattern_index <= bit_pattern_index + 3'd1;
      // >= rather than == keeps the index in range if the mode flips mid-pixel.
      if (stream_pattern_of) begin
        if (pixel_bit_index >= last_bit) pixel_bit_index <= 5'd0;
        else                             pixel_bit_index <= pixel_bit_index + 5'd1;
      end
      neoData <= tick_high;
    end
  end

endmodule

// File: tb/tb_neopixel_stream.sv
// Directed bench for neopixel_stream: waveform high-tick counts, strobe timing,
// end-index compare, abort, async reset and synchronous init.
module tb_neopixel_stream;

  localparam int BUFFER_END = 7;
  localparam int BB = 3;

  logic          clk7mhz = 1'b0;
  logic          rstn = 1'b0;
  logic          reg_ctrl_init = 1'b0;
  logic          reg_ctrl_run = 1'b0;
  logic          reg_ctrl_limit = 1'b0;
  logic          reg_ctrl_32bit = 1'b0;
  logic          state = 1'b0;
  logic [12:0]   reg_max = 13'd0;
  logic [BB-1:0] pixel_index = '0;
  logic [7:0]    pixel_data;
  logic [BB-1:0] pixel_addr;
  logic          neoData;
  logic [2:0]    bit_pattern_index;
  logic [4:0]    pixel_bit_index;
  logic [BB-1:0] pixel_index_max;
  logic          stream_output, stream_reset, stream_pattern_of, stream_bit_of, stream_pixel_of;

  logic [7:0] mem [0:BUFFER_END];
  logic [3:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  assign pixel_data = mem[pixel_addr];

  neopixel_stream #(.BUFFER_END(BUFFER_END)) u_dut (
    .clk7mhz(clk7mhz), .rstn(rstn), .reg_ctrl_init(reg_ctrl_init),
    .reg_ctrl_run(reg_ctrl_run), .reg_ctrl_limit(reg_ctrl_limit),
    .reg_ctrl_32bit(reg_ctrl_32bit), .state(state), .reg_max(reg_max),
    .pixel_index(pixel_index), .pixel_data(pixel_data), .pixel_addr(pixel_addr),
    .neoData(neoData), .bit_pattern_index(bit_pattern_index),
    .pixel_bit_index(pixel_bit_index), .pixel_index_max(pixel_index_max),
    .stream_output(stream_output), .stream_reset(stream_reset),
    .stream_pattern_of(stream_pattern_of), .stream_bit_of(stream_bit_of),
    .stream_pixel_of(stream_pixel_of)
  );

  // clock / watchdog
  always #5 clk7mhz = ~clk7mhz;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk7mhz);
    #1;
  endtask

  // Waveform model: a '1' is 5 high ticks, a '0' is 2, MSB first.
  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_q.push_back(b[i] ? 4'd5 : 4'd2);
  endtask

  // Runs one pixel from an idle, cleared block. Cycle 1 is the first cycle with
  // stream_output high; neoData for bit n, tick t is seen in cycle 8n+t+2.
  task automatic send(input string tag, input int nbits, input logic [BB-1:0] pi,
                      input logic exp_pixof);
    int hi;
    int bitof_cycle;
    int bitof_count;
    logic pixof_at;
    logic [3:0] exp_hi;
    logic [BB-1:0] exp_addr;
    hi = 0; bitof_cycle = 0; bitof_count = 0; pixof_at = 1'b0;
    pixel_index = pi;
    reg_ctrl_run = 1'b1;
    for (int k = 1; k <= nbits * 8 + 1; k++) begin
      @(negedge clk7mhz);
      if (stream_bit_of) begin
        bitof_count++;
        bitof_cycle = k;
        pixof_at = stream_pixel_of;
      end
      if (k == 1) check({tag, ":first_tick_low"}, neoData, 0);
      if (k <= nbits * 8 && (k - 1) % 8 == 0) begin
        exp_addr = reg_ctrl_32bit ? pi + BB'((k - 1) / 64) : pi;
        if ((k - 1) % 64 == 0) check({tag, ":addr"}, pixel_addr, exp_addr);
      end
      if (k >= 2) begin
        if ((k - 2) % 8 == 0) hi = 0;
        hi += int'(neoData);
        if ((k - 2) % 8 == 7) begin
          exp_hi = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hF;
          check({tag, ":hi_ticks"}, hi, exp_hi);
        end
      end
    end
    @(posedge clk7mhz);
    #1;
    reg_ctrl_run = 1'b0;
    wait_edges(1);
    check({tag, ":bit_of_count"}, bitof_count, 1);
    check({tag, ":bit_of_cycle"}, bitof_cycle, nbits * 8);
    check({tag, ":pixel_of"}, pixof_at, exp_pixof);
    check({tag, ":q_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i <= BUFFER_END; i++) mem[i] = 8'h00;

    // reset
    wait_edges(2);
    check("rst_bpi", bit_pattern_index, 0);
    check("rst_pbi", pixel_bit_index, 0);
    check("rst_neo", neoData, 0);
    rstn = 1'b1;
    wait_edges(1);
    check("idle_output", stream_output, 0);
    check("idle_reset", stream_reset, 0);
    check("idle_pattern_of", stream_pattern_of, 0);

    // end index select, with truncation of reg_max
    check("max_buffer_end", pixel_index_max, 7);
    reg_max = 13'h1F05;
    reg_ctrl_limit = 1'b1;
    #1 check("max_reg_trunc", pixel_index_max, 5);
    reg_ctrl_limit = 1'b0;
    wait_edges(1);

    // 8-bit mode
    mem[0] = 8'hA5; push_byte(8'hA5);
    send("b8_p0", 8, 3'd0, 1'b0);
    mem[6] = 8'h3C; push_byte(8'h3C);
    send("b8_p6", 8, 3'd6, 1'b0);
    mem[7] = 8'hC3; push_byte(8'hC3);
    send("b8_p7_last", 8, 3'd7, 1'b1);

    // 32-bit mode, slot byte 3 (0xFF) must not be sent
    reg_ctrl_32bit = 1'b1;
    mem[0] = 8'h80; mem[1] = 8'h00; mem[2] = 8'h01; mem[3] = 8'hFF;
    push_byte(8'h80); push_byte(8'h00); push_byte(8'h01);
    send("b32_p0", 24, 3'd0, 1'b0);

    // 32-bit with programmed end index 5
    reg_ctrl_limit = 1'b1;
    mem[4] = 8'hF0; mem[5] = 8'h0F; mem[6] = 8'hAA;
    push_byte(8'hF0); push_byte(8'h0F); push_byte(8'hAA);
    send("lim_p4", 24, 3'd4, 1'b1);
    push_byte(8'h01); push_byte(8'hFF); push_byte(8'hF0);
    send("lim_p2_edge", 24, 3'd2, 1'b1);
    push_byte(8'h80); push_byte(8'h00); push_byte(8'h01);
    send("lim_p0", 24, 3'd0, 1'b0);
    reg_ctrl_limit = 1'b0;
    reg_ctrl_32bit = 1'b0;

    // latch state holds everything low even with run set
    state = 1'b1;
    reg_ctrl_run = 1'b1;
    wait_edges(5);
    check("latch_reset", stream_reset, 1);
    check("latch_output", stream_output, 0);
    check("latch_neo", neoData, 0);
    check("latch_bpi", bit_pattern_index, 0);
    check("latch_pbi", pixel_bit_index, 0);
    state = 1'b0;
    reg_ctrl_run = 1'b0;
    wait_edges(1);

    // run dropped mid-bit
    mem[0] = 8'hA5;
    pixel_index = 3'd0;
    reg_ctrl_run = 1'b1;
    wait_edges(9);
    check("abort_pre_bpi", bit_pattern_index, 1);
    check("abort_pre_pbi", pixel_bit_index, 1);
    check("abort_pre_neo", neoData, 1);
    reg_ctrl_run = 1'b0;
    #1 check("abort_output", stream_output, 0);
    wait_edges(1);
    check("abort_bpi", bit_pattern_index, 0);
    check("abort_pbi", pixel_bit_index, 0);
    check("abort_neo", neoData, 0);

    // async reset mid-bit
    reg_ctrl_run = 1'b1;
    wait_edges(10);
    check("arst_pre_bpi", bit_pattern_index, 2);
    check("arst_pre_neo", neoData, 1);
    #2 rstn = 1'b0;
    #1;
    check("arst_bpi", bit_pattern_index, 0);
    check("arst_pbi", pixel_bit_index, 0);
    check("arst_neo", neoData, 0);
    reg_ctrl_run = 1'b0;
    #1 rstn = 1'b1;
    wait_edges(1);

    // synchronous init mid-bit
    reg_ctrl_run = 1'b1;
    wait_edges(10);
    check("init_pre_pbi", pixel_bit_index, 1);
    check("init_pre_neo", neoData, 1);
    reg_ctrl_init = 1'b1;
    @(negedge clk7mhz);
    check("init_not_yet", bit_pattern_index, 2);
    wait_edges(1);
    check("init_bpi", bit_pattern_index, 0);
    check("init_pbi", pixel_bit_index, 0);
    check("init_neo", neoData, 0);
    wait_edges(1);
    check("init_hold_bpi", bit_pattern_index, 0);
    reg_ctrl_init = 1'b0;
    reg_ctrl_run = 1'b0;
    wait_edges(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/neopixel_stream.md
# neopixel_stream

Bit-serialiser and timing sequencer for the NeoPixel (WS2812) output path, clocked at 7 MHz. From a byte-addressed pixel buffer it generates the per-bit 8-tick waveform on `neoData`, walks the bit and byte counters, and raises the overflow strobes the parent uses to advance `pixel_index` and enter the latch/reset period. It sits between the bus-side register and buffer block and the pin. The parent owns `state`, `pixel_index` and the reset-delay counter.

## Interface
- `BUFFER_END`, default 59: last valid byte index of the pixel buffer; buffer size is `BUFFER_END+1`.
- `BUFFER_BITS`, default `clog2(BUFFER_END+1)` (localparam): width of byte indices.

- `clk7mhz`  in  1  7 MHz clock; all logic on its rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `reg_ctrl_init`  in  1  synchronous clear of all counters.
- `reg_ctrl_run`  in  1  transmit enable.
- `reg_ctrl_limit`  in  1  1 = use `reg_max` as the end index; 0 = use `BUFFER_END`.
- `reg_ctrl_32bit`  in  1  1 = 4-byte pixel slots, 3 bytes sent per slot; 0 = every byte sent.
- `state`  in  1  0 = TRANSMIT, 1 = RESET (latch).
- `reg_max`  in  13  programmed last byte index.
- `pixel_index`  in  BUFFER_BITS  first byte of the current pixel.
- `pixel_data`  in  8  byte at `pixel_addr`; asynchronous read, valid in the same cycle.
- `pixel_addr`  out  BUFFER_BITS  byte address being serialised.
- `neoData`  out  1  registered serial output.
- `bit_pattern_index`  out  3  tick within the current bit, 0..7.
- `pixel_bit_index`  out  5  bit within the current pixel.
- `pixel_index_max`  out  BUFFER_BITS  effective end index.
- `stream_output`, `stream_reset`, `stream_pattern_of`, `stream_bit_of`, `stream_pixel_of`  out  1 each  status and overflow strobes.

## Operation
- `stream_output` = (`state`==0) && `reg_ctrl_run`.
- `stream_reset` = (`state`==1), independent of `reg_ctrl_run`.
- `pixel_index_max`:
  - `reg_ctrl_limit`=1: `reg_max[BUFFER_BITS-1:0]`, truncated.
  - `reg_ctrl_limit`=0: `BUFFER_END`.
- Bits per pixel: 8 in 8-bit mode, 24 in 32-bit mode. `last_bit` is 7 or 23 respectively.
- `bit_pattern_index`:
  - Increments every clock while `stream_output`=1 and wraps 7→0.
  - Cleared to 0 whenever `stream_output`=0.
- `stream_pattern_of` = `stream_output` && `bit_pattern_index`==7 (combinational).
- `pixel_bit_index`:
  - Increments on `stream_pattern_of`; after `last_bit` it wraps to 0.
  - Cleared whenever `stream_output`=0.
- `stream_bit_of` = `stream_pattern_of` && `pixel_bit_index`==`last_bit`.
- `stream_pixel_of` = `stream_bit_of` && the last-pixel compare. Compute at BUFFER_BITS+1 width, no wrap:
  - 8-bit mode: `pixel_index` >= `pixel_index_max`.
  - 32-bit mode: `pixel_index`+3 >= `pixel_index_max`.
- `pixel_addr`:
  - 8-bit mode: `pixel_index`.
  - 32-bit mode: `pixel_index` + `pixel_bit_index[4:3]`.
  - Slot byte 3 is never sent.
- Transmitted bit = `pixel_data[7 - pixel_bit_index[2:0]]`, MSB first.
- Waveform per bit is 8 ticks (1.14 µs):
  - '0': high while `bit_pattern_index` < 2 (286 ns).
  - '1': high while `bit_pattern_index` < 5 (714 ns).
  - Low for the remaining ticks.
- `neoData` is 0 whenever `stream_output`=0. This includes the RESET state, which supplies the ≥50 µs latch low.
- `reg_ctrl_init`=1 clears both counters and `neoData` on the next edge. It has priority over counting.
- Changing `reg_ctrl_32bit` or `reg_ctrl_limit` mid-stream is unsupported. The block only guarantees no X and no counter out of range (`pixel_bit_index` is clamped by the wrap rule).

## Timing
- `rstn` low asynchronously clears `bit_pattern_index`, `pixel_bit_index` and `neoData` to 0.
- Reset values of the combinational outputs follow from their inputs: `stream_output`=0 when `reg_ctrl_run`=0.
- `neoData` is registered and lags `bit_pattern_index` and `pixel_addr` by exactly 1 clock.
- The first high tick appears 1 clock after `stream_output` rises.
- All strobes are combinational and 1 cycle wide. The parent samples them on the same edge that advances the counters.
- On `stream_pixel_of` the parent sets `state`=1. On the next cycle `stream_output`=0, the counters clear, and `neoData` goes low one clock later.
- `reg_ctrl_run` falling mid-bit aborts immediately: counters clear, and `neoData` goes low the following clock. Restart begins at bit 0 of `pixel_index`.

## Test plan
- 8-bit mode, `BUFFER_END`=3, byte0=0xA5, run=1, state=0:
  - `neoData` high-tick counts per bit are 5,2,5,2,2,5,2,5.
  - `stream_bit_of` fires at cycle 64.
  - `stream_pixel_of`=0.
- Same setup with `pixel_index`=3: `stream_pixel_of` fires with `stream_bit_of` at cycle 64.
- 32-bit mode, slot bytes 0x80,0x00,0x01,0xFF:
  - 24 bits sent, from `pixel_addr` 0,1,2 only.
  - High-tick counts: bit0=5, bits 1–22=2, bit23=5.
  - `stream_bit_of` fires at cycle 192.
- `reg_ctrl_limit`=1, `reg_max`=5, 32-bit mode:
  - `pixel_index_max`=5.
  - `stream_pixel_of` at `pixel_index`=4; none at `pixel_index`=0.
- state=1 with run=1: `stream_reset`=1, `stream_output`=0, `neoData`=0, counters held at 0.
- `rstn` pulsed low mid-bit, and separately `reg_ctrl_init`=1 mid-bit: counters and `neoData` are 0 immediately (async) or on the next edge (init) respectively.
